multiport_cache: RTL
====================

Name: multiport_cache

Overview:
- Parametrised, fully associative, word-addressed cache shared by NUM_PORTS processor ports.
- Successor to the two-processor cache: adds a valid/ready handshake, round-robin arbitration across N ports, and hit/miss reporting.
- Adds store-miss allocation with FIFO replacement, synchronous reset, and hit/miss statistics counters.
- Sits between the processor models and the memory model.
- Misses are reported, never serviced from memory.

Parameters:
- NUM_PORTS, 2, number of requesting processor ports (>=1).
- LINES, 16, number of cache lines (power of two, >=2).
- TAG_W, 11, tag width.
- OFFSET_W, 1, word-offset width; words per line = 2**OFFSET_W.
- DATA_W, 8, word width.
- CNT_W, 16, width of the hit/miss counters.

Ports:
- clk  in  1  clock, all state updates on posedge.
- reset  in  1  synchronous active-high reset.
- req_valid  in  NUM_PORTS  per-port request valid.
- req_store  in  NUM_PORTS  per-port op: 1=store, 0=load.
- req_tag  in  NUM_PORTS*TAG_W  per-port tag; port p occupies [p*TAG_W +: TAG_W].
- req_offset  in  NUM_PORTS*OFFSET_W  per-port word offset, packed the same way.
- req_wdata  in  NUM_PORTS*DATA_W  per-port store data, packed the same way.
- req_ready  out  NUM_PORTS  one-hot grant; the handshake completes on an edge where valid and ready are both 1.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_port  out  max(1,$clog2(NUM_PORTS))  id of the port being answered.
- rsp_store  out  1  op type of the answered request.
- rsp_hit  out  1  1=tag hit.
- rsp_tag  out  TAG_W  echoed tag.
- rsp_offset  out  OFFSET_W  echoed offset.
- rsp_data  out  DATA_W  loaded word, or written word for a store.
- hit_count  out  CNT_W  saturating count of hits.
- miss_count  out  CNT_W  saturating count of misses.

Behaviour:
Reset
- Synchronous; highest priority.
- Clears all line valid bits; data and tag arrays are not cleared.
- repl_ptr=0; rr_ptr=0; state=IDLE.
- rsp_valid=0; all rsp_* fields 0; both counters 0.
- An in-flight request is dropped and gets no response.

State machine and grant
- States: IDLE and LOOKUP.
- req_ready is combinational and nonzero only in IDLE.
- Grant goes to the first port with req_valid=1, searching upward (with wrap) from rr_ptr.
- On a handshake edge:
  - the granted port's fields are latched;
  - rr_ptr becomes granted+1 mod NUM_PORTS;
  - state goes to LOOKUP.
- Ungranted requesters must hold req_valid and their fields stable until they are granted.

LOOKUP (one cycle), then state goes to IDLE
- Tag is compared in parallel against all valid lines.
- Load hit: rsp_data = the addressed word; rsp_hit=1.
- Load miss: rsp_data=0; rsp_hit=0; no allocation.
- Store hit: the addressed word is written; rsp_data = wdata; rsp_hit=1.
- Store miss: allocate a victim.
  - Victim = lowest-index invalid line if one exists; otherwise repl_ptr, and repl_ptr increments mod LINES (wraps LINES-1 to 0).
  - Victim gets the new tag, valid=1, the addressed word = wdata, all other words = 0.
  - rsp_hit=0; rsp_data = wdata.
- Duplicate tags cannot arise.
- hit_count or miss_count increments by 1 and holds at 2**CNT_W-1.

Response timing
- rsp_* are registered at the end of LOOKUP.
- rsp_valid=1 for exactly the cycle after the LOOKUP edge, then 0.
- rsp_* hold their values while rsp_valid=0.
- There is no response backpressure.

Latency and throughput
- Handshake at edge E: response visible after edge E+1.
- The next grant is possible in that same cycle.
- Peak throughput is one request per 2 cycles.

Test Plan:
- Reset, then port0 load tag=0x050 offset=0 -> rsp_valid one cycle later; rsp_hit=0, rsp_data=0, miss_count=1.
- Port0 store tag=0x050 offset=1 data=0xA5, then load offset=1 -> store rsp_hit=0, rsp_data=0xA5; load rsp_hit=1, rsp_data=0xA5; load offset=0 returns 0x00.
- Ports 0 and 1 both valid for 4 requests each from reset -> grants alternate 0,1,0,1...; rsp_port alternates; each response arrives 2 cycles apart.
- Store-miss 17 distinct tags T0..T16 (LINES=16) -> T16 evicts line 0 (T0); load T0 misses, load T1 and T16 hit; next allocation evicts line 1.
- Assert reset during LOOKUP -> no rsp_valid pulse; outputs 0; a prior stored tag now misses.
- Force CNT_W=2 and issue 5 hits -> hit_count sticks at 3.

Source files
------------

// File: rtl/multiport_cache.sv
// rtl/multiport_cache.sv - fully associative word-addressed cache shared by round-robin arbitrated ports
//
// One request is accepted per IDLE cycle and looked up in the following
// LOOKUP cycle. The result is reported as a one-cycle registered response.
// Misses are reported only; store misses allocate a line, load misses do not.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_store        per-port request valid and op (1=store)
//   req_tag/offset/wdata       per-port fields, port p at [p*W +: W]
//   req_ready                  one-hot grant, nonzero only in IDLE
//   rsp_valid                  one-cycle response pulse
//   rsp_port/store/hit         answered port, op type, tag hit
//   rsp_tag/offset/data        echoed address and loaded/written word
//   hit_count/miss_count       saturating statistics counters

module multiport_cache #(
  parameter int NUM_PORTS = 2,
  parameter int LINES     = 16,
  parameter int TAG_W     = 11,
  parameter int OFFSET_W  = 1,
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 16
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic [NUM_PORTS-1:0]                            req_valid,
  input  logic [NUM_PORTS-1:0]                            req_store,
  input  logic [NUM_PORTS*TAG_W-1:0]                      req_tag,
  input  logic [NUM_PORTS*OFFSET_W-1:0]                   req_offset,
  input  logic [NUM_PORTS*DATA_W-1:0]                     req_wdata,
  output logic [NUM_PORTS-1:0]                            req_ready,
  output logic                                            rsp_valid,
  output logic [((NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1)-1:0] rsp_port,
  output logic                                            rsp_store,
  output logic                                            rsp_hit,
  output logic [TAG_W-1:0]                                rsp_tag,
  output logic [OFFSET_W-1:0]                             rsp_offset,
  output logic [DATA_W-1:0]                               rsp_data,
  output logic [CNT_W-1:0]                                hit_count,
  output logic [CNT_W-1:0]                                miss_count
);

  localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int IDX_W  = $clog2(LINES);
  localparam int WORDS  = 2 ** OFFSET_W;

  typedef enum logic {IDLE, LOOKUP} state_t;

  state_t               state;
  logic [PORT_W-1:0]    rr_ptr;
  logic [IDX_W-1:0]     repl_ptr;

  // Cache storage: only the valid bits are reset.
  logic [LINES-1:0]     line_valid;
  logic [TAG_W-1:0]     line_tag  [LINES];
  logic [DATA_W-1:0]    line_data [LINES][WORDS];

  // Request captured at the handshake edge.
  logic [PORT_W-1:0]    lat_port;
  logic                 lat_store;
  logic [TAG_W-1:0]     lat_tag;
  logic [OFFSET_W-1:0]  lat_offset;
  logic [DATA_W-1:0]    lat_wdata;

  // Round-robin grant search.
  logic                 gnt_found;
  logic [PORT_W-1:0]    gnt_idx;
  logic [PORT_W-1:0]    rr_next;
  int                   scan;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan      = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      scan = int'(rr_ptr) + i;
      if (scan >= NUM_PORTS) begin
        scan = scan - NUM_PORTS;
      end
      if (!gnt_found && req_valid[scan]) begin
        gnt_found = 1'b1;
        gnt_idx   = PORT_W'(scan);
      end
    end
  end

  // NUM_PORTS need not be a power of two, so wrap explicitly.
  assign rr_next = (gnt_idx == PORT_W'(NUM_PORTS - 1)) ? '0 : gnt_idx + PORT_W'(1);

  always_comb begin
    req_ready = '0;
    if (state == IDLE && gnt_found) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  // Parallel tag match plus lowest-index free line search.
  logic                 hit;
  logic [IDX_W-1:0]     hit_idx;
  logic                 free_found;
  logic [IDX_W-1:0]     free_idx;
  logic [IDX_W-1:0]     victim;

  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < LINES; i++) begin
      if (!hit && line_valid[i] && line_tag[i] == lat_tag) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!free_found && !line_valid[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // Free lines are filled first; FIFO replacement only once the cache is full.
  assign victim = free_found ? free_idx : repl_ptr;

  // Tag/data arrays carry no reset; a reset during LOOKUP suppresses the write.
  always_ff @(posedge clk) begin
    if (!reset && state == LOOKUP && lat_store) begin
      if (hit) begin
        line_data[hit_idx][lat_offset] <= lat_wdata;
      end else begin
        line_tag[victim] <= lat_tag;
        for (int w = 0; w < WORDS; w++) begin
          line_data[victim][w] <= (w == int'(lat_offset)) ? lat_wdata : '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      repl_ptr   <= '0;
      line_valid <= '0;
      lat_port   <= '0;
      lat_store  <= 1'b0;
      lat_tag    <= '0;
      lat_offset <= '0;
      lat_wdata  <= '0;
      rsp_valid  <= 1'b0;
      rsp_port   <= '0;
      rsp_store  <= 1'b0;
      rsp_hit    <= 1'b0;
      rsp_tag    <= '0;
      rsp_offset <= '0;
      rsp_data   <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_found) begin
            lat_port   <= gnt_idx;
            lat_store  <= req_store[gnt_idx];
            lat_tag    <= req_tag[int'(gnt_idx)*TAG_W +: TAG_W];
            lat_offset <= req_offset[int'(gnt_idx)*OFFSET_W +: OFFSET_W];
            lat_wdata  <= req_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
            rr_ptr     <= rr_next;
            state      <= LOOKUP;
          end
        end
        LOOKUP: begin
          rsp_valid  <= 1'b1;
          rsp_port   <= lat_port;
          rsp_store  <= lat_store;
          rsp_hit    <= hit;
          rsp_tag    <= lat_tag;
          rsp_offset <= lat_offset;
          if (lat_store) begin
            rsp_data <= lat_wdata;
          end else if (hit) begin
            rsp_data <= line_data[hit_idx][lat_offset];
          end else begin
            rsp_data <= '0;
          end
          if (hit) begin
            if (hit_count != '1) begin
              hit_count <= hit_count + CNT_W'(1);
            end
          end else begin
            if (miss_count != '1) begin
              miss_count <= miss_count + CNT_W'(1);
            end
          end
          if (lat_store && !hit) begin
            line_valid[victim] <= 1'b1;
            // LINES is a power of two, so the pointer wraps naturally.
            if (!free_found) begin
              repl_ptr <= repl_ptr + IDX_W'(1);
            end
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
